// File: rtl/lc3b_mem_arbiter.sv
// Two-port to one-port memory arbiter for the pipelined LC-3b core: serializes fetch and data accesses.
// Optional grant counters are built only when ARB_PERF_EN is defined; otherwise both count outputs read 0.
module lc3b_mem_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_imem_read,
  input  logic [15:0]          i_imem_address,
  output logic [15:0]          o_imem_rdata,
  output logic                 o_imem_resp,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [15:0]          i_mem_address,
  input  logic [15:0]          i_mem_wdata,
  input  logic [1:0]           i_mem_byte_enable,
  output logic [15:0]          o_mem_rdata,
  output logic                 o_mem_resp,
  output logic                 o_pmem_read,
  output logic                 o_pmem_write,
  output logic [15:0]          o_pmem_address,
  output logic [15:0]          o_pmem_wdata,
  output logic [1:0]           o_pmem_byte_enable,
  input  logic [15:0]          i_pmem_rdata,
  input  logic                 i_pmem_resp,
  output logic [CNT_WIDTH-1:0] o_imem_grant_count,
  output logic [CNT_WIDTH-1:0] o_dmem_grant_count
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t r_state;
  logic   r_last_grant_d;
  logic   r_pmem_read;
  logic   r_pmem_write;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_i_done;
  logic w_d_done;

  assign w_i_req   = i_imem_read;
  assign w_d_req   = i_mem_read | i_mem_write;
  // On a tie the port that was not served last wins.
  assign w_grant_i = w_i_req & (~w_d_req | r_last_grant_d);
  assign w_i_done  = (r_state == SERVE_I) & i_pmem_resp;
  assign w_d_done  = (r_state == SERVE_D) & i_pmem_resp;

  // Commands are latched at grant so a requester dropping mid-access cannot abort the downstream cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state      <= SERVE_I;
            r_pmem_read  <= 1'b1;
            r_pmem_write <= 1'b0;
          end else if (w_d_req) begin
            r_state      <= SERVE_D;
            r_pmem_read  <= i_mem_read & ~i_mem_write;
            r_pmem_write <= i_mem_write;
          end
        end
        SERVE_I: begin
          if (i_pmem_resp) begin
            r_state        <= IDLE;
            r_last_grant_d <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
          end
        end
        SERVE_D: begin
          if (i_pmem_resp) begin
            r_state        <= IDLE;
            r_last_grant_d <= 1'b1;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_pmem_address     = 16'h0000;
    o_pmem_wdata       = 16'h0000;
    o_pmem_byte_enable = 2'b00;
    case (r_state)
      SERVE_I: begin
        o_pmem_address     = i_imem_address;
        o_pmem_byte_enable = 2'b11;
      end
      SERVE_D: begin
        o_pmem_address     = i_mem_address;
        o_pmem_wdata       = i_mem_wdata;
        o_pmem_byte_enable = i_mem_byte_enable;
      end
      default: begin
        o_pmem_address     = 16'h0000;
        o_pmem_wdata       = 16'h0000;
        o_pmem_byte_enable = 2'b00;
      end
    endcase
  end

  assign o_pmem_read  = r_pmem_read;
  assign o_pmem_write = r_pmem_write;
  assign o_imem_resp  = w_i_done;
  assign o_mem_resp   = w_d_done;
  assign o_imem_rdata = i_pmem_rdata;
  assign o_mem_rdata  = i_pmem_rdata;

`ifdef ARB_PERF_EN
  logic [CNT_WIDTH-1:0] r_imem_cnt;
  logic [CNT_WIDTH-1:0] r_dmem_cnt;

  // Completed-transaction counters; they wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_imem_cnt <= '0;
      r_dmem_cnt <= '0;
    end else begin
      if (w_i_done) r_imem_cnt <= r_imem_cnt + CNT_WIDTH'(1);
      if (w_d_done) r_dmem_cnt <= r_dmem_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_imem_grant_count = r_imem_cnt;
  assign o_dmem_grant_count = r_dmem_cnt;
`else
  assign o_imem_grant_count = '0;
  assign o_dmem_grant_count = '0;
`endif

endmodule
